vec_result_unpacker: RTL

- Consumer end of the processor's vector result stream: the processor presents a 64-bit `data` word qualified by a single-cycle `enable` strobe, with no backpressure.
- This block captures each strobed word into a small FIFO and unpacks it into 8-bit pixels.
- Pixels go out on a valid/ready stream toward the image sink (VGA frame buffer / host dump).
- It also tracks frame boundaries and flags any words lost to overflow.

---
 rtl/vec_sink_pkg.sv | 15 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/vec_result_unpacker.sv | 112 +++++++++++
 3 files changed

// File: rtl/vec_sink_pkg.sv
// rtl/vec_sink_pkg.sv - shared constants and types for the vector result sink
package vec_sink_pkg;

  localparam int DATA_W       = 64;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = DATA_W / PIX_W;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } unpack_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push while full is taken when a pop happens on the same edge
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit tells a full ring from an empty one
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vec_result_unpacker.sv
// rtl/vec_result_unpacker.sv - buffers strobed result words and streams them out MSB-first as pixels
module vec_result_unpacker #(
  parameter int DATA_W      = 64,
  parameter int PIX_W       = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = 8192
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               data,
  input  logic                            enable,
  output logic [PIX_W-1:0]                pix_data,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic                            pix_last,
  output logic                            frame_done,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  import vec_sink_pkg::*;

  localparam int PPW = DATA_W / PIX_W;
  localparam int IW  = $clog2(PPW);
  localparam int FW  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  unpack_state_t     state;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic [FW-1:0]     fcnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              last_pix;
  logic              at_frame_end;
  logic              drop;

  assign last_pix     = (idx == IW'(PPW-1));
  assign at_frame_end = (fcnt == FW'(FRAME_WORDS-1));
  assign fifo_pop     = !fifo_empty &&
                        ((state == IDLE) || (pix_ready && last_pix));
  assign drop         = enable && fifo_full && !fifo_pop;
  assign pix_data     = shreg[DATA_W-1 -: PIX_W];

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enable),
    .wdata (data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      fcnt       <= '0;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg     <= fifo_rdata;
            idx       <= '0;
            pix_valid <= 1'b1;
            pix_last  <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (pix_ready) begin
            if (!last_pix) begin
              shreg    <= shreg << PIX_W;
              idx      <= idx + 1'b1;
              // Flag the upcoming final pixel of the last word in the frame
              pix_last <= (idx == IW'(PPW-2)) && at_frame_end;
            end else begin
              fcnt       <= at_frame_end ? '0 : fcnt + 1'b1;
              frame_done <= at_frame_end;
              pix_last   <= 1'b0;
              if (!fifo_empty) begin
                shreg <= fifo_rdata;
                idx   <= '0;
              end else begin
                shreg     <= '0;
                idx       <= '0;
                pix_valid <= 1'b0;
                state     <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
